vga_timing: RTL
===============

# vga_timing

Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock. It drives `sx`/`sy` to the digit renderer and `hsync`/`vsync` to the connector. It also holds the frame-synchronous copy of the 12-digit game display word, so the digits shown never change mid-frame (no tearing). It sits directly upstream of the digit-renderer stage, which consumes `sx`, `sy` and `numbers_out`.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz → 25 MHz).
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk` input 1: system clock, 100 MHz. One clock domain only.
- `rst` input 1: asynchronous reset, active-high.
- `numbers_in` input 48: 12 BCD digits from the game logic; the most significant nibble is digit 0.
- `pix_en` output 1: one-`clk` pixel strobe.
- `sx` output 10: horizontal position, 0 to H_TOTAL-1.
- `sy` output 10: vertical position, 0 to V_TOTAL-1.
- `hsync` output 1: horizontal sync, active-low.
- `vsync` output 1: vertical sync, active-low.
- `de` output 1: high while in the visible area.
- `frame_start` output 1: one-`clk` pulse when the raster enters (0,0).
- `numbers_out` output 48: frame-stable copy of the display word, fed to the renderer.

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both totals must be ≤ 1024.
- Divider `div` counts 0 to CLK_DIV-1 and wraps.
- `pix_en` is combinational: `pix_en` = (`div` == CLK_DIV-1).
- On each `clk` edge where `pix_en`=1:
  - `sx` increments.
  - When `sx` = H_TOTAL-1, `sx` wraps to 0 and `sy` increments.
  - When `sy` = V_TOTAL-1 at that wrap, `sy` wraps to 0.
- `hsync`, `vsync`, `de` and `frame_start` are registered. They are computed from the next counter values, so they are always consistent with the `sx`/`sy` currently presented:
  - `hsync` = 0 iff H_ACTIVE+H_FP ≤ `sx` < H_ACTIVE+H_FP+H_SYNC (656 to 751).
  - `vsync` = 0 iff V_ACTIVE+V_FP ≤ `sy` < V_ACTIVE+V_FP+V_SYNC (490 to 491).
  - `de` = (`sx` < H_ACTIVE) && (`sy` < V_ACTIVE).
  - `frame_start` = 1 for exactly the one `clk` cycle following the edge that moved the counters to (0,0). It is 0 otherwise.
- Display-word shadow register (see Configuration): `numbers_out` loads `numbers_in` on the same edge that moves the counters to (0,0).
- Counter and shadow state are a three-state raster FSM, implicit in `sx`/`sy`:
  - ACTIVE: `de`=1.
  - HBLANK: `sx` ≥ H_ACTIVE.
  - VBLANK: `sy` ≥ V_ACTIVE.
  - Transitions occur only on `pix_en`.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `div`=0.
  - `sx`=H_TOTAL-1, `sy`=V_TOTAL-1.
  - `hsync`=1, `vsync`=1, `de`=0, `frame_start`=0.
  - `numbers_out`=0.
- First `pix_en` after reset release occurs on the CLK_DIV-th rising edge. That edge moves the counters to (0,0), sets `de`=1 and pulses `frame_start`. The first frame is therefore full length.
- Latency from counters to sync outputs: 0 cycles. This alignment is mandatory; the renderer colours pixels combinationally from `sx`/`sy`.
- Counter outputs hold constant for CLK_DIV `clk` cycles per pixel.
- Reset asserted mid-frame aborts the frame. After release, timing restarts exactly as after power-on.
- `numbers_in` changes between frame boundaries never appear on `numbers_out`.
- A `numbers_in` change on the same edge as the frame boundary is captured (the sampled value is the one present at that edge).

## Configuration
- Macro: `VGA_TIMING_SHADOW_EN`.
- Defined: `numbers_out` is the registered shadow described above. It updates only on entry to (0,0) and resets to 0.
- Undefined: `numbers_out` = `numbers_in` combinationally (pass-through). There is no shadow register and `numbers_out` has no reset dependence.
- All other behaviour is identical with and without the macro.

## Test plan
- Reset and release: `rst`=1 for 3 clks, then release.
  - During reset: `sx`=799, `sy`=524, `hsync`=1, `vsync`=1, `de`=0.
  - 4th edge after release: `sx`=0, `sy`=0, `de`=1, `frame_start`=1 for exactly 1 clk.
- Line timing: count `pix_en` per line → exactly 800. `hsync` low exactly 96 pixels, starting at `sx`=656. `de` high for `sx` 0 to 639 only.
- Frame timing: `frame_start` period = 1,680,000 clks (800×525×4). `vsync` low for `sy` 490 and 491 only. `sy` wraps 524 → 0.
- Shadow, macro defined:
  - Set `numbers_in`=48'h0123_4567_8901 before frame N, then 48'h9999_9999_9999 at `sy`=200.
  - `numbers_out` stays 48'h0123_4567_8901 until `frame_start`, then shows 48'h9999_9999_9999.
- Shadow, macro undefined: the same stimulus makes `numbers_out` follow `numbers_in` in the same cycle.
- Mid-frame reset: assert `rst` at `sx`=300, `sy`=100, asynchronously, between clock edges.
  - Outputs go to reset values before the next edge.
  - After release, the reset-and-release sequence repeats exactly.

Source files
------------

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// 640x480@60 Hz VGA raster timing generator running from the 100 MHz system
// clock, plus a frame-synchronous copy of the 12-digit display word so the
// digit renderer never shows a word that changed mid-frame.
//
// Ports:
//   clk          in   1  system clock (single domain)
//   rst          in   1  asynchronous reset, active-high
//   numbers_in   in  48  12 BCD digits from game logic, digit 0 in [47:44]
//   pix_en       out  1  one-clk pixel strobe (combinational, div == CLK_DIV-1)
//   sx           out 10  horizontal position, 0 .. H_TOTAL-1
//   sy           out 10  vertical position, 0 .. V_TOTAL-1
//   hsync        out  1  horizontal sync, active-low
//   vsync        out  1  vertical sync, active-low
//   de           out  1  high inside the visible area
//   frame_start  out  1  one-clk pulse when the raster enters (0,0)
//   numbers_out  out 48  display word presented to the renderer
//
// Configuration macro:
//   VGA_TIMING_SHADOW_EN  defined   : numbers_out is a shadow register loaded
//                                     on entry to (0,0), reset to 0
//                         undefined : numbers_out = numbers_in (pass-through)
//
// H_TOTAL and V_TOTAL must both be <= 1024 (10-bit counters).
// -----------------------------------------------------------------------------
module vga_timing #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [47:0] numbers_in,
   output logic        pix_en,
   output logic [9:0]  sx,
   output logic [9:0]  sy,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        frame_start,
   output logic [47:0] numbers_out
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   // Raster region; implicit in the counters, registered alongside them so
   // that de comes straight from a flop.
   typedef enum logic [1:0] {
      ST_ACTIVE,
      ST_HBLANK,
      ST_VBLANK
   } raster_state_t;

   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_sx;
   logic [9:0]       r_sy;
   raster_state_t    r_state;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_frame_start;

   logic [DIV_W-1:0] w_div_next;
   logic [9:0]       w_sx_next;
   logic [9:0]       w_sy_next;
   raster_state_t    w_state_next;
   logic             w_hsync_next;
   logic             w_vsync_next;
   logic             w_frame_start_next;
   logic             w_pix_en;

   assign w_pix_en = (r_div == DIV_LAST);

   // State register. Reset parks the counters on the last pixel of the frame
   // so the first pixel strobe after release lands on (0,0).
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div         <= '0;
         r_sx          <= H_LAST;
         r_sy          <= V_LAST;
         r_state       <= ST_VBLANK;
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_div         <= w_div_next;
         r_sx          <= w_sx_next;
         r_sy          <= w_sy_next;
         r_state       <= w_state_next;
         r_hsync       <= w_hsync_next;
         r_vsync       <= w_vsync_next;
         r_frame_start <= w_frame_start_next;
      end
   end

   // Next-state: divider and raster counters; counters move only on pix_en.
   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_div_next = r_div + 1'b1;
      w_sx_next  = r_sx;
      w_sy_next  = r_sy;
      if (w_pix_en) begin
         w_div_next = '0;
         if (r_sx == H_LAST) begin
            w_sx_next = '0;
            w_sy_next = (r_sy == V_LAST) ? 10'd0 : r_sy + 10'd1;
         end else begin
            w_sx_next = r_sx + 10'd1;
         end
      end
   end

   // Output decode from the *next* counter values: registering these gives
   // zero latency relative to the sx/sy being presented.
   always_comb begin
      w_state_next = ST_ACTIVE;
      if (w_sy_next >= V_VIS) begin
         w_state_next = ST_VBLANK;
      end else if (w_sx_next >= H_VIS) begin
         w_state_next = ST_HBLANK;
      end
      w_hsync_next       = !((w_sx_next >= HS_START) && (w_sx_next < HS_END));
      w_vsync_next       = !((w_sy_next >= VS_START) && (w_sy_next < VS_END));
      // The counters sit on (0,0) for CLK_DIV clocks; only the entering edge
      // counts as a frame start.
      w_frame_start_next = w_pix_en && (w_sx_next == 10'd0) && (w_sy_next == 10'd0);
   end

   assign pix_en      = w_pix_en;
   assign sx          = r_sx;
   assign sy          = r_sy;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign de          = (r_state == ST_ACTIVE);
   assign frame_start = r_frame_start;

`ifdef VGA_TIMING_SHADOW_EN
   // Shadow of the display word, captured on the edge entering (0,0) so the
   // renderer sees one value for the whole frame.
   logic [47:0] r_numbers;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_numbers <= '0;
      end else if (w_frame_start_next) begin
         r_numbers <= numbers_in;
      end
   end

   assign numbers_out = r_numbers;
`else
   assign numbers_out = numbers_in;
`endif

endmodule
